// File: rtl/scroll_seq_ctrl.sv
// ---------------------------------------------------------------------------
// scroll_seq_ctrl
// Owns the vertical scroll row for the scrolling-image address generators
// (the credit roll and the song cover/lyric strip). A STOP/PLAY/PAUSE
// sequencer advances the row only on frame boundaries, so the image never
// tears mid-frame. It supports normal, fast-forward and reverse stepping
// with wrap-around, and exports a registered row base address.
//
// Ports:
//   i_clk          pixel/system clock
//   i_rst_n        asynchronous active-low reset
//   i_frame_tick   one-cycle pulse at start of vertical blank
//   i_play_pause   one-cycle pulse, toggles play/pause (STOP -> PLAY)
//   i_restart      one-cycle pulse, back to STOP at row 0 (highest priority)
//   i_fwd          level, fast-forward by FAST_STEP rows per step
//   i_bwd          level, reverse by one row per step
//   o_position     current scroll row, 0..LINES-1
//   o_base_addr    o_position*ROW_WORDS, one cycle behind o_position
//   o_playing      high in PLAY
//   o_paused       high in PAUSE
//   o_wrap_pulse   one-cycle pulse on the cycle o_position takes a wrapped value
// ---------------------------------------------------------------------------
module scroll_seq_ctrl #(
  parameter int unsigned LINES     = 240,
  parameter int unsigned ROW_WORDS = 160,
  parameter int unsigned STEP_DIV  = 1,
  parameter int unsigned FAST_STEP = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_play_pause,
  input  logic        i_restart,
  input  logic        i_fwd,
  input  logic        i_bwd,
  output logic [9:0]  o_position,
  output logic [15:0] o_base_addr,
  output logic        o_playing,
  output logic        o_paused,
  output logic        o_wrap_pulse
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned SUM_W  = POS_W + 1;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PRE_W  = $clog2(STEP_DIV) + 1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t             r_state;
  logic [POS_W-1:0]   r_position;
  logic [ADDR_W-1:0]  r_base_addr;
  logic [PRE_W-1:0]   r_prescaler;
  logic               r_wrap;
  logic               r_playing;
  logic               r_paused;

  state_t             w_state_next;
  logic [POS_W-1:0]   w_pos_next;
  logic [PRE_W-1:0]   w_pre_next;
  logic               w_wrap_next;
  logic               w_step;
  logic [POS_W-1:0]   w_step_pos;
  logic               w_step_wrap;
  logic [SUM_W-1:0]   w_sum;

  // Step fires on the frame tick that completes the prescaler period in PLAY
  assign w_step = (r_state == ST_PLAY) && i_frame_tick &&
                  (r_prescaler == PRE_W'(STEP_DIV - 1));

  // Fast-forward sum is one bit wider so the overflow past LINES is visible
  assign w_sum = SUM_W'(r_position) + SUM_W'(FAST_STEP);

  // Candidate row and wrap flag for a step, chosen by the direction levels
  always_comb begin
    w_step_pos  = r_position;
    w_step_wrap = 1'b0;
    if (i_bwd && !i_fwd) begin
      if (r_position == '0) begin
        w_step_pos  = POS_W'(LINES - 1);
        w_step_wrap = 1'b1;
      end else begin
        w_step_pos  = r_position - POS_W'(1);
      end
    end else if (i_fwd && !i_bwd) begin
      if (w_sum >= SUM_W'(LINES)) begin
        w_step_pos  = POS_W'(w_sum - SUM_W'(LINES));
        w_step_wrap = 1'b1;
      end else begin
        w_step_pos  = POS_W'(w_sum);
      end
    end else begin
      if (r_position == POS_W'(LINES - 1)) begin
        w_step_pos  = '0;
        w_step_wrap = 1'b1;
      end else begin
        w_step_pos  = r_position + POS_W'(1);
      end
    end
  end

  // Next-state, prescaler and position; the step uses the pre-transition state
  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_position;
    w_pre_next   = r_prescaler;
    w_wrap_next  = 1'b0;

    case (r_state)
      ST_STOP: begin
        w_pre_next = '0;
        if (i_play_pause) begin
          w_state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_step) begin
          w_pre_next  = '0;
          w_pos_next  = w_step_pos;
          w_wrap_next = w_step_wrap;
        end else if (i_frame_tick) begin
          w_pre_next = r_prescaler + PRE_W'(1);
        end
        if (i_play_pause) begin
          w_state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (i_play_pause) begin
          w_state_next = ST_PLAY;
        end
      end
      default: begin
        w_state_next = ST_STOP;
        w_pre_next   = '0;
      end
    endcase

    // Restart overrides any toggle or step in the same cycle
    if (i_restart) begin
      w_state_next = ST_STOP;
      w_pos_next   = '0;
      w_pre_next   = '0;
      w_wrap_next  = 1'b0;
    end
  end

  // State, position and status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_STOP;
      r_position  <= '0;
      r_prescaler <= '0;
      r_wrap      <= 1'b0;
      r_playing   <= 1'b0;
      r_paused    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_position  <= w_pos_next;
      r_prescaler <= w_pre_next;
      r_wrap      <= w_wrap_next;
      r_playing   <= (w_state_next == ST_PLAY);
      r_paused    <= (w_state_next == ST_PAUSE);
    end
  end

  // Row base address follows the position register by one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base_addr <= '0;
    end else begin
      r_base_addr <= ADDR_W'(32'(r_position) * 32'(ROW_WORDS));
    end
  end

  assign o_position   = r_position;
  assign o_base_addr  = r_base_addr;
  assign o_playing    = r_playing;
  assign o_paused     = r_paused;
  assign o_wrap_pulse = r_wrap;

endmodule

// File: tb/tb_scroll_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scroll_seq_ctrl
// Directed bench for scroll_seq_ctrl: a vector table for the basic
// play/pause/step behaviour, plus hand-written sequences for wrap, fast and
// reverse stepping, restart priority, async reset and a STEP_DIV=3 instance.
// ---------------------------------------------------------------------------
module tb_scroll_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        play_pause;
  logic        restart;
  logic        fwd;
  logic        bwd;

  logic [9:0]  pos1;
  logic [15:0] base1;
  logic        play1, pause1, wrap1;

  logic [9:0]  pos3;
  logic [15:0] base3;
  logic        play3, pause3, wrap3;

  int n_checks;
  int n_errors;

  scroll_seq_ctrl #(.LINES(240), .ROW_WORDS(160), .STEP_DIV(1), .FAST_STEP(4)) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (frame_tick),
    .i_play_pause (play_pause),
    .i_restart    (restart),
    .i_fwd        (fwd),
    .i_bwd        (bwd),
    .o_position   (pos1),
    .o_base_addr  (base1),
    .o_playing    (play1),
    .o_paused     (pause1),
    .o_wrap_pulse (wrap1)
  );

  scroll_seq_ctrl #(.LINES(240), .ROW_WORDS(160), .STEP_DIV(3), .FAST_STEP(4)) u_dut3 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (frame_tick),
    .i_play_pause (play_pause),
    .i_restart    (restart),
    .i_fwd        (fwd),
    .i_bwd        (bwd),
    .o_position   (pos3),
    .o_base_addr  (base3),
    .o_playing    (play3),
    .o_paused     (pause3),
    .o_wrap_pulse (wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rs, pp, ft, fw, bw;
    int   pos, base;
    logic play, pause, wrap;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are stable on return
  task automatic cyc(input logic rs, input logic pp, input logic ft,
                     input logic fw, input logic bw);
    @(negedge clk);
    restart    = rs;
    play_pause = pp;
    frame_tick = ft;
    fwd        = fw;
    bwd        = bw;
    @(posedge clk);
    #1;
    restart    = 1'b0;
    play_pause = 1'b0;
    frame_tick = 1'b0;
    fwd        = 1'b0;
    bwd        = 1'b0;
  endtask

  task automatic check1(input string tag, input int p, input int b,
                        input int pl, input int pa, input int w);
    check({tag, "_pos"},   int'(pos1),   p);
    check({tag, "_base"},  int'(base1),  b);
    check({tag, "_play"},  int'(play1),  pl);
    check({tag, "_pause"}, int'(pause1), pa);
    check({tag, "_wrap"},  int'(wrap1),  w);
  endtask

  initial begin
    int exp3[6];
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    play_pause = 1'b0;
    restart    = 1'b0;
    fwd        = 1'b0;
    bwd        = 1'b0;

    //           rs pp ft fw bw   pos  base  pl pa wr
    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,   0,    0, 1'b0,1'b0,1'b0};
    vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,   0,    0, 1'b1,1'b0,1'b0};
    vt[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,   1,    0, 1'b1,1'b0,1'b0};
    vt[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,   2,  160, 1'b1,1'b0,1'b0};
    vt[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,   3,  320, 1'b1,1'b0,1'b0};
    vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,   3,  480, 1'b1,1'b0,1'b0};
    vt[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,   2,  480, 1'b1,1'b0,1'b0};
    vt[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,   6,  320, 1'b1,1'b0,1'b0};
    vt[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,   7,  960, 1'b1,1'b0,1'b0};
    vt[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,   7, 1120, 1'b0,1'b1,1'b0};
    vt[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,   7, 1120, 1'b0,1'b1,1'b0};
    vt[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,   7, 1120, 1'b1,1'b0,1'b0};
    vt[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0,   8, 1120, 1'b0,1'b1,1'b0};
    vt[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,   8, 1280, 1'b1,1'b0,1'b0};
    vt[14] = '{1'b1,1'b1,1'b1,1'b0,1'b0,   0, 1280, 1'b0,1'b0,1'b0};
    vt[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,   0,    0, 1'b0,1'b0,1'b0};
    vt[16] = '{1'b0,1'b0,1'b1,1'b0,1'b0,   0,    0, 1'b0,1'b0,1'b0};

    // Reset state, checked while reset is still asserted
    #12;
    check1("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven basic behaviour
    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].rs, vt[i].pp, vt[i].ft, vt[i].fw, vt[i].bw);
      check1($sformatf("v%0d", i), vt[i].pos, vt[i].base,
             int'(vt[i].play), int'(vt[i].pause), int'(vt[i].wrap));
    end

    // Forward wrap 239 -> 0
    cyc(0, 1, 0, 0, 0);
    repeat (239) cyc(0, 0, 1, 0, 0);
    check("a_pos239", int'(pos1), 239);
    cyc(0, 0, 1, 0, 0);
    check1("a_wrap", 0, 38240, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check1("a_after", 0, 0, 1, 0, 0);

    // Fast-forward wrap 238 -> 2, then fwd+bwd at 238 -> 239 without wrap
    repeat (238) cyc(0, 0, 1, 0, 0);
    check("b_pos238", int'(pos1), 238);
    cyc(0, 0, 1, 1, 0);
    check("b_ff_pos", int'(pos1), 2);
    check("b_ff_wrap", int'(wrap1), 1);
    cyc(1, 0, 0, 0, 0);
    check1("b_restart", 0, 320, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (238) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 1);
    check("b_both_pos", int'(pos1), 239);
    check("b_both_wrap", int'(wrap1), 0);

    // Reverse wrap 0 -> 239, then pause ignores frame ticks
    cyc(0, 0, 1, 0, 0);
    check("c_pos0", int'(pos1), 0);
    cyc(0, 0, 1, 0, 1);
    check("c_rev_pos", int'(pos1), 239);
    check("c_rev_wrap", int'(wrap1), 1);
    cyc(0, 1, 0, 0, 0);
    check("c_paused", int'(pause1), 1);
    repeat (5) cyc(0, 0, 1, 0, 0);
    check1("c_hold", 239, 38240, 0, 1, 0);

    // Restart beats play_pause and a wrapping step in the same cycle
    cyc(0, 1, 0, 0, 0);
    check("d_play", int'(play1), 1);
    cyc(1, 1, 1, 0, 0);
    check1("d_restart", 0, 38240, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("d_base0", int'(base1), 0);

    // Asynchronous reset mid-PLAY, seen without a clock edge
    cyc(0, 1, 0, 0, 0);
    repeat (100) cyc(0, 0, 1, 0, 0);
    check("e_pos100", int'(pos1), 100);
    #1;
    rst_n = 1'b0;
    #1;
    check1("e_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // STEP_DIV=3 instance: steps on every third tick, prescaler held in PAUSE
    exp3 = '{0, 0, 1, 1, 1, 2};
    cyc(0, 1, 0, 0, 0);
    check("f_play", int'(play3), 1);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 0, 0);
      check($sformatf("f_tick%0d", k + 1), int'(pos3), exp3[k]);
    end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("f_tick8", int'(pos3), 2);
    cyc(0, 1, 0, 0, 0);
    check("f_paused", int'(pause3), 1);
    cyc(0, 0, 1, 0, 0);
    check("f_pause_tick", int'(pos3), 2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("f_resume_pos", int'(pos3), 3);
    check("f_resume_wrap", int'(wrap3), 0);
    cyc(0, 0, 0, 0, 0);
    check("f_base", int'(base3), 480);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scroll_seq_ctrl.md
Name: scroll_seq_ctrl

Overview:
Sequencer that owns the vertical scroll position for the scrolling-image address generators. These are the credit roll and the song cover/lyric strip. It runs a STOP/PLAY/PAUSE state machine and steps the row position only on frame boundaries, so the image never tears mid-frame. It handles normal, fast-forward and reverse stepping with wrap-around. It also exports a registered row base address that the address generator adds to its in-window pixel offset.

Parameters:
LINES, 240, number of scroll rows in the image; position range 0..LINES-1
ROW_WORDS, 160, memory words per image row; LINES*ROW_WORDS must be <= 65536
STEP_DIV, 1, frame ticks per scroll step (>=1)
FAST_STEP, 4, rows advanced per step while fwd is held (1..LINES-1)

Ports:
clk  in  1  pixel/system clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
play_pause  in  1  one-cycle pulse (already debounced/one-pulsed); toggles play/pause
restart  in  1  one-cycle pulse; return to STOP at row 0
fwd  in  1  level; fast-forward while high
bwd  in  1  level; reverse while high
position  out  10  current scroll row, registered
base_addr  out  16  position*ROW_WORDS, registered
playing  out  1  high in PLAY
paused  out  1  high in PAUSE
wrap_pulse  out  1  one-cycle pulse when position wraps in either direction

Behaviour:
- Reset (rst low, async) forces the following; all resume on the first clk edge after rst rises:
  - state=STOP, position=0, base_addr=0, prescaler=0
  - playing=0, paused=0, wrap_pulse=0
- States and transitions, evaluated each clk edge:
  - restart=1: go to STOP, position=0, prescaler=0. Takes priority over play_pause and stepping in the same cycle.
  - STOP + play_pause: go to PLAY.
  - PLAY + play_pause: go to PAUSE.
  - PAUSE + play_pause: go to PLAY.
  - No other transitions.
- Prescaler (width ceil(log2(STEP_DIV))+1):
  - Counts frame_tick pulses only in PLAY; holds in PAUSE; cleared in STOP.
  - A step fires when frame_tick=1 and prescaler==STEP_DIV-1; the prescaler returns to 0 on that step.
- Step decision uses the state before any same-cycle transition. PLAY with play_pause and a firing frame_tick therefore still steps, then enters PAUSE.
- Step arithmetic (position update on the step cycle):
  - bwd=1, fwd=0: position = (position==0) ? LINES-1 : position-1; wrap when position was 0.
  - fwd=1, bwd=0: s = position+FAST_STEP, computed 11 bits wide; position = (s>=LINES) ? s-LINES : s; wrap when s>=LINES.
  - Otherwise (both low, or both high): position = (position==LINES-1) ? 0 : position+1; wrap when position was LINES-1.
- wrap_pulse:
  - High exactly on the cycle position takes its wrapped value; low otherwise.
  - Never asserted by restart or reset.
- base_addr:
  - Equals position*ROW_WORDS with 1-cycle latency: registered from the position register value.
  - Product computed 16 bits wide, no truncation, given the parameter constraint.
- playing and paused: decoded from the state register, no extra latency.
- frame_tick outside PLAY: ignored. fwd/bwd: no effect except on step cycles.
- position never leaves the range 0..LINES-1.

Test Plan:
- Reset release, then play_pause, then 3 frame_ticks (STEP_DIV=1) -> playing=1; position 0,1,2,3; base_addr 160,320,480, each one cycle after its position.
- PLAY at position 239 + frame_tick -> position=0, wrap_pulse high for one cycle, base_addr=0 on the next cycle.
- PLAY at position 238, fwd=1, frame_tick -> position=2, wrap_pulse=1. With fwd=bwd=1 at 238 -> position=239, no wrap.
- PLAY at position 0, bwd=1, frame_tick -> position=239, wrap_pulse=1. Then play_pause -> paused=1; 5 frame_ticks leave position=239.
- STEP_DIV=3 in PLAY: 6 frame_ticks -> position advances on ticks 3 and 6 only. Pause after tick 2, resume, 1 tick -> step fires (prescaler held).
- restart with play_pause and a firing frame_tick in the same cycle -> STOP, position=0, no wrap_pulse. rst low mid-PLAY at position 100 -> immediate position=0, playing=0 without a clk edge.
